reg_transport_fwd_queue: RTL and testbench
==========================================

Name: reg_transport_fwd_queue

Overview:
- Parametrised successor to the single register-transport bundle (value + address).
- Buffers up to DEPTH pending register writebacks in order between the execute/memory stages and the register file.
- Drains them in order to the register file through a valid/ready port.
- Exposes READ_PORTS combinational forwarding lookups, so decode sees the newest in-flight value of any register before it reaches the register file.

Parameters:
- REG_WIDTH, 32, width of a register value
- ADDR_WIDTH, 5, width of a register address
- DEPTH, 4, number of buffered writebacks (power of two, ≥2)
- READ_PORTS, 2, number of independent forwarding lookup ports

Ports:
- clk  in  1  system clock, all state updates on rising edge
- nRst  in  1  synchronous active-low reset
- flush  in  1  discard all buffered entries
- wr_valid  in  1  producer offers a writeback
- wr_ready  out  1  queue can accept a writeback
- wr_value  in  REG_WIDTH  writeback value
- wr_addr  in  ADDR_WIDTH  writeback destination register
- out_valid  out  1  head entry is available to the register file
- out_ready  in  1  register file consumes the head entry
- out_value  out  REG_WIDTH  head entry value
- out_addr  out  ADDR_WIDTH  head entry address
- rd_addr  in  READ_PORTS*ADDR_WIDTH  lookup addresses, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_hit  out  READ_PORTS  port i has an in-flight match
- rd_value  out  READ_PORTS*REG_WIDTH  forwarded value, port i at bits [i*REG_WIDTH +: REG_WIDTH]
- count  out  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Storage: circular buffer of DEPTH {value, addr} entries, with head pointer, tail pointer and count; pointers wrap modulo DEPTH.
- Reset (nRst low at a clock edge):
  - head, tail and count go to 0; out_valid is 0 and rd_hit is all 0.
  - wr_ready is forced 0 while nRst is low; it is 1 the first cycle after release.
  - out_value and out_addr read 0 when out_valid is 0 (outputs gated, not raw storage).
- Push: occurs when wr_valid && wr_ready.
  - wr_ready = (count < DEPTH) && nRst; it does not depend on out_ready (no full pass-through).
  - A push with wr_addr == 0 is accepted (handshake completes) but not stored: tail and count are unchanged.
- Pop: occurs when out_valid && out_ready.
  - out_valid = (count != 0).
  - Head data is driven directly from storage, giving zero-cycle latency from a stored entry to the out port.
- Latency:
  - An entry written at edge N is visible on the out port and the forwarding ports in the cycle after edge N.
  - There is no same-cycle bypass from wr_* to rd_* or out_*.
- Simultaneous push and pop: both take effect, count is unchanged, and both pointers advance.
  - When full, no push occurs (wr_ready is 0) even if a pop happens in that cycle.
- Forwarding (combinational, per port):
  - All valid entries are compared to rd_addr; the newest matching entry (nearest to tail) wins.
  - rd_hit=1 and rd_value is that entry's value.
  - No match, or rd_addr==0: rd_hit=0 and rd_value=0.
  - Entries popped this cycle still forward during this cycle; they are gone next cycle.
- Flush: at the edge, head, tail and count go to 0.
  - Flush overrides any push or pop in the same cycle; the push handshake is not considered completed.
  - The producer must re-present the entry.
- Occupancy bounds: count never exceeds DEPTH and never underflows. Pop with count==0 is impossible because out_valid is 0.

Test Plan:
- Reset then idle: hold nRst=0 for 2 cycles → wr_ready=0, out_valid=0, count=0; release → wr_ready=1, count=0.
- Fill and drain: push addr 1..4 with values 0x11..0x44, out_ready=0.
  - Expect count=4 and wr_ready=0; a 5th push is not accepted.
  - Then out_ready=1 → out_addr 1,2,3,4 in order with matching values, count returns to 0.
- Newest-wins forwarding: push (5,0xAAAA) then (5,0xBBBB); rd_addr port0=5, port1=6.
  - Expect rd_hit=2'b01 and port0 rd_value=0xBBBB.
  - After popping one entry, still 0xBBBB; after popping both, hit=0.
- x0 handling: push (0,0xDEAD) → handshake completes, count unchanged; rd_addr=0 → rd_hit=0, rd_value=0.
- Simultaneous push/pop and wrap: with DEPTH=4 and count=3, do concurrent push/pop for 8 cycles.
  - Expect count stays 3, out order preserved across pointer wrap, and forwarding correct throughout.
- Flush mid-operation: count=3 with push and pop both asserted plus flush in the same cycle.
  - Next cycle count=0, out_valid=0, rd_hit=0, and the pushed entry is absent.
  - Repeat with nRst=0 instead of flush → same result.

Source files
------------

// File: rtl/reg_transport_fwd_queue.sv
// In-order writeback queue between execute/memory and the register file, with
// combinational newest-wins forwarding lookups for decode.
module reg_transport_fwd_queue #(
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned READ_PORTS = 2
) (
    input  logic                             clk,
    input  logic                             nRst,
    input  logic                             flush,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [REG_WIDTH-1:0]             wr_value,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [REG_WIDTH-1:0]             out_value,
    output logic [ADDR_WIDTH-1:0]            out_addr,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [READ_PORTS-1:0]            rd_hit,
    output logic [READ_PORTS*REG_WIDTH-1:0]  rd_value,
    output logic [$clog2(DEPTH):0]           count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [REG_WIDTH-1:0]  val_q  [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  push, store, pop;

    assign wr_ready  = (count_q < CW'(DEPTH)) && nRst;
    assign out_valid = (count_q != '0);
    assign push      = wr_valid && wr_ready;
    // Writes to x0 complete the handshake but are never stored.
    assign store     = push && (wr_addr != '0);
    assign pop       = out_valid && out_ready;
    assign count     = count_q;
    assign out_value = out_valid ? val_q[head_q]  : '0;
    assign out_addr  = out_valid ? addr_q[head_q] : '0;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (!nRst || flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (store) tail_d = tail_q + 1'b1;
            if (pop)   head_d = head_q + 1'b1;
            case ({store, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
        if (nRst && !flush && store) begin
            val_q[tail_q]  <= wr_value;
            addr_q[tail_q] <= wr_addr;
        end
    end

    // Scan oldest to newest so the last match (nearest tail) wins.
    always_comb begin
        rd_hit   = '0;
        rd_value = '0;
        for (int unsigned p = 0; p < READ_PORTS; p++) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if ((CW'(k) < count_q) && (rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH] != '0) &&
                    (addr_q[head_q + PW'(k)] == rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    rd_hit[p]                     = 1'b1;
                    rd_value[p*REG_WIDTH +: REG_WIDTH] = val_q[head_q + PW'(k)];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_transport_fwd_queue.sv
// Randomised and directed bench for reg_transport_fwd_queue against a queue-based model.
module tb_reg_transport_fwd_queue;

    localparam int RW = 32;
    localparam int AW = 5;
    localparam int D  = 4;
    localparam int RP = 2;
    localparam int CW = $clog2(D) + 1;

    logic            clk = 1'b0;
    logic            nRst, flush, wr_valid, wr_ready, out_valid, out_ready;
    logic [RW-1:0]   wr_value, out_value;
    logic [AW-1:0]   wr_addr, out_addr;
    logic [RP*AW-1:0] rd_addr;
    logic [RP-1:0]   rd_hit;
    logic [RP*RW-1:0] rd_value;
    logic [CW-1:0]   count;

    always #5 clk = ~clk;

    reg_transport_fwd_queue #(
        .REG_WIDTH(RW), .ADDR_WIDTH(AW), .DEPTH(D), .READ_PORTS(RP)
    ) dut (
        .clk(clk), .nRst(nRst), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_value(wr_value), .wr_addr(wr_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value), .out_addr(out_addr),
        .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_value(rd_value), .count(count)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [RW-1:0] v;
    } ent_t;

    ent_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare every output against the model's in-flight list (oldest at q[0]).
    task automatic verify();
        logic          hit;
        logic [RW-1:0] val;
        logic [AW-1:0] ra;
        check("count", 64'(count), 64'(q.size()));
        check("wr_ready", 64'(wr_ready), 64'(nRst && (q.size() < D)));
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check("out_value", 64'(out_value), (q.size() != 0) ? 64'(q[0].v) : 64'd0);
        check("out_addr", 64'(out_addr), (q.size() != 0) ? 64'(q[0].a) : 64'd0);
        for (int p = 0; p < RP; p++) begin
            ra  = rd_addr[p*AW +: AW];
            hit = 1'b0;
            val = '0;
            if (ra != 0) begin
                for (int k = q.size() - 1; k >= 0; k--) begin
                    if (q[k].a == ra) begin
                        hit = 1'b1;
                        val = q[k].v;
                        break;
                    end
                end
            end
            check($sformatf("rd_hit%0d", p), 64'(rd_hit[p]), 64'(hit));
            check($sformatf("rd_value%0d", p), 64'(rd_value[p*RW +: RW]), 64'(val));
        end
    endtask

    // Drive one cycle, check at the falling edge, advance the model, land 1 after the rising edge.
    task automatic cycle(input logic n, input logic f, input logic wv, input logic [AW-1:0] wa,
                         input logic [RW-1:0] wd, input logic ordy,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        bit do_push, do_pop;
        nRst = n; flush = f; wr_valid = wv; wr_addr = wa; wr_value = wd;
        out_ready = ordy; rd_addr = {r1, r0};
        #4;
        verify();
        do_push = wv && n && (q.size() < D);
        do_pop  = ordy && (q.size() != 0);
        if (!n || f) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push && wa != 0) q.push_back('{a: wa, v: wd});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, r0, r1);
    endtask

    initial begin
        nRst = 1'b0; flush = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_value = '0;
        out_ready = 1'b0; rd_addr = '0;
        @(posedge clk);
        #1;

        // Reset then idle
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        check("rst_wr_ready", 64'(wr_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        idle('0, '0);
        check("rel_wr_ready", 64'(wr_ready), 64'd1);
        check("rel_count", 64'(count), 64'd0);

        // Fill and drain
        for (int i = 1; i <= 4; i++)
            cycle(1'b1, 1'b0, 1'b1, AW'(i), RW'(i * 32'h11), 1'b0, AW'(i), '0);
        check("fill_count", 64'(count), 64'd4);
        check("fill_wr_ready", 64'(wr_ready), 64'd0);
        cycle(1'b1, 1'b0, 1'b1, 5'd5, 32'h55, 1'b0, 5'd5, '0);
        check("fifth_count", 64'(count), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            check("drain_addr", 64'(out_addr), 64'(i));
            check("drain_value", 64'(out_value), 64'(i * 32'h11));
            cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, AW'(i), '0);
        end
        check("drain_count", 64'(count), 64'd0);

        // Newest wins
        cycle(1'b1, 1'b0, 1'b1, 5'd5, 32'hAAAA, 1'b0, 5'd5, 5'd6);
        cycle(1'b1, 1'b0, 1'b1, 5'd5, 32'hBBBB, 1'b0, 5'd5, 5'd6);
        check("nw_hit", 64'(rd_hit), 64'b01);
        check("nw_value", 64'(rd_value[RW-1:0]), 64'hBBBB);
        cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 5'd5, 5'd6);
        check("nw_pop1_value", 64'(rd_value[RW-1:0]), 64'hBBBB);
        cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 5'd5, 5'd6);
        check("nw_pop2_hit", 64'(rd_hit), 64'b00);

        // x0 writeback
        cycle(1'b1, 1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 5'd0);
        check("x0_count", 64'(count), 64'd0);
        check("x0_hit", 64'(rd_hit), 64'd0);
        check("x0_value", 64'(rd_value), 64'd0);

        // Concurrent push/pop across pointer wrap
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b0, 1'b1, AW'(7 + i), $urandom, 1'b0, '0, '0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 1'b1, AW'(10 + i), $urandom, 1'b1,
                  AW'($urandom_range(7, 17)), AW'($urandom_range(7, 17)));
            check("wrap_count", 64'(count), 64'd3);
        end

        // Flush overrides push/pop
        cycle(1'b1, 1'b1, 1'b1, 5'd20, 32'h1234, 1'b1, 5'd20, 5'd17);
        check("flush_count", 64'(count), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_hit", 64'(rd_hit), 64'd0);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 1'b0, 1'b1, AW'(21 + i), $urandom, 1'b0, '0, '0);
        cycle(1'b0, 1'b0, 1'b1, 5'd20, 32'h5678, 1'b1, 5'd20, 5'd21);
        check("rstmid_count", 64'(count), 64'd0);
        check("rstmid_out_valid", 64'(out_valid), 64'd0);
        check("rstmid_hit", 64'(rd_hit), 64'd0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 29) == 0),
                  $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 2) != 0,
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
